// File: rtl/core_pkg.sv
// Shared core types: store sizes, store-align FSM states and the byte-enable
// helper also used by the load path.
package core_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } store_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } store_state_e;

    // Wide enough for a 64-bit word pair (2*8 byte lanes).
    localparam int unsigned BE_WIDE_W = 16;

    // Enables for (1 << size) bytes starting at byte offset ofs.
    function automatic logic [BE_WIDE_W-1:0] be_wide_f(input logic [1:0] size,
                                                       input logic [2:0] ofs);
        logic [BE_WIDE_W-1:0] ones;
        ones = (BE_WIDE_W'(1) << (4'd1 << size)) - BE_WIDE_W'(1);
        return ones << ofs;
    endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// Combinational lane shifter: places the low size bytes of the store operand
// at their byte offset inside a two-word window and builds matching enables.
module store_lane_shifter
    import core_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]                  size,
    input  logic [$clog2(DATA_W/8)-1:0] ofs,
    input  logic [DATA_W-1:0]           data,
    output logic [2*DATA_W-1:0]         wdata_wide,
    output logic [2*(DATA_W/8)-1:0]     be_wide
);

    localparam int unsigned NB = DATA_W / 8;

    logic [NB-1:0]     lane_mask;
    logic [DATA_W-1:0] data_masked;

    assign lane_mask = NB'(be_wide_f(size, 3'd0));

    // Drop operand bytes above the store size so they never reach memory.
    always_comb begin
        data_masked = '0;
        for (int i = 0; i < int'(NB); i++) begin
            data_masked[8*i +: 8] = lane_mask[i] ? data[8*i +: 8] : 8'h00;
        end
    end

    assign wdata_wide = {DATA_W'(0), data_masked} << {ofs, 3'b000};
    assign be_wide    = (2*NB)'(be_wide_f(size, 3'(ofs)));

endmodule

// File: rtl/store_align_unit.sv
// Registered store formatter between execute and the data-memory port.
// Define MISALIGN_SPLIT_EN to split word-crossing stores into two beats.
module store_align_unit
    import core_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                reqValid,
    output logic                reqReady,
    input  logic [1:0]          storeSize,
    input  logic [ADDR_W-1:0]   storeAddr,
    input  logic [DATA_W-1:0]   storeData,
    output logic                memValid,
    input  logic                memReady,
    output logic [ADDR_W-1:0]   memAddr,
    output logic [DATA_W-1:0]   memWdata,
    output logic [DATA_W/8-1:0] memBe,
    output logic                storeDone,
    output logic                misalignErr
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFS_W = $clog2(NB);

    store_state_e state_q, state_d;

    logic [OFS_W-1:0]    ofs_c;
    logic [ADDR_W-1:0]   base_addr_c;
    logic [2*DATA_W-1:0] wdata_wide_c;
    logic [2*NB-1:0]     be_wide_c;
    logic                cross_c;
    logic                bad_size_c;
    logic                reject_c;
    logic                load0_c;
    logic                done_c;
    logic                err_c;

    assign ofs_c       = storeAddr[OFS_W-1:0];
    assign base_addr_c = {storeAddr[ADDR_W-1:OFS_W], OFS_W'(0)};
    assign cross_c     = |be_wide_c[2*NB-1:NB];
    assign bad_size_c  = (storeSize == SZ_D) && (DATA_W != 64);

    store_lane_shifter #(.DATA_W(DATA_W)) u_shifter (
        .size       (storeSize),
        .ofs        (ofs_c),
        .data       (storeData),
        .wdata_wide (wdata_wide_c),
        .be_wide    (be_wide_c)
    );

`ifdef MISALIGN_SPLIT_EN
    logic                load1_c;
    logic                cross_q;
    logic [ADDR_W-1:0]   addr1_q;
    logic [DATA_W-1:0]   wdata1_q;
    logic [NB-1:0]       be1_q;

    assign reject_c = bad_size_c;
`else
    logic [3:0] size_bytes_c;
    logic       unaligned_c;
    logic       unused_hi;

    // Without splitting, anything not naturally aligned is refused outright.
    assign size_bytes_c = 4'd1 << storeSize;
    assign unaligned_c  = |(ofs_c & OFS_W'(size_bytes_c - 4'd1));
    assign reject_c     = bad_size_c | cross_c | unaligned_c;
    assign unused_hi    = ^wdata_wide_c[2*DATA_W-1:DATA_W];
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load0_c = 1'b0;
        done_c  = 1'b0;
        err_c   = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        load1_c = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    if (reject_c) begin
                        err_c = 1'b1;
                    end else begin
                        state_d = ST_BEAT0;
                        load0_c = 1'b1;
                    end
                end
            end
            ST_BEAT0: begin
                if (memReady) begin
`ifdef MISALIGN_SPLIT_EN
                    if (cross_q) begin
                        state_d = ST_BEAT1;
                        load1_c = 1'b1;
                    end else
`endif
                    begin
                        state_d = ST_IDLE;
                        done_c  = 1'b1;
                    end
                end
            end
`ifdef MISALIGN_SPLIT_EN
            ST_BEAT1: begin
                if (memReady) begin
                    state_d = ST_IDLE;
                    done_c  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-facing registers; they double as the beat-0 holding registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            reqReady    <= 1'b1;
            memValid    <= 1'b0;
            storeDone   <= 1'b0;
            misalignErr <= 1'b0;
            memAddr     <= '0;
            memWdata    <= '0;
            memBe       <= '0;
        end else begin
            reqReady    <= (state_d == ST_IDLE);
            memValid    <= (state_d != ST_IDLE);
            storeDone   <= done_c;
            misalignErr <= err_c;
            if (load0_c) begin
                memAddr  <= base_addr_c;
                memWdata <= wdata_wide_c[DATA_W-1:0];
                memBe    <= be_wide_c[NB-1:0];
            end
`ifdef MISALIGN_SPLIT_EN
            else if (load1_c) begin
                memAddr  <= addr1_q;
                memWdata <= wdata1_q;
                memBe    <= be1_q;
            end
`endif
            else if (state_d == ST_IDLE) begin
                memAddr  <= '0;
                memWdata <= '0;
                memBe    <= '0;
            end
        end
    end

`ifdef MISALIGN_SPLIT_EN
    // Upper half of the window, held until beat 0 is accepted.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cross_q  <= 1'b0;
            addr1_q  <= '0;
            wdata1_q <= '0;
            be1_q    <= '0;
        end else if (load0_c) begin
            cross_q  <= cross_c;
            addr1_q  <= base_addr_c + ADDR_W'(NB);
            wdata1_q <= wdata_wide_c[2*DATA_W-1:DATA_W];
            be1_q    <= be_wide_c[2*NB-1:NB];
        end
    end
`endif

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench for store_align_unit (32-bit data); follows
// MISALIGN_SPLIT_EN to pick the expected split/reject behaviour.
module tb_store_align_unit;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned NB     = 4;

    logic              clk = 1'b0;
    logic              resetN;
    logic              reqValid;
    logic              reqReady;
    logic [1:0]        storeSize;
    logic [ADDR_W-1:0] storeAddr;
    logic [DATA_W-1:0] storeData;
    logic              memValid;
    logic              memReady;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [NB-1:0]     memBe;
    logic              storeDone;
    logic              misalignErr;

    int checks = 0;
    int errors = 0;

    store_align_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .storeSize   (storeSize),
        .storeAddr   (storeAddr),
        .storeData   (storeData),
        .memValid    (memValid),
        .memReady    (memReady),
        .memAddr     (memAddr),
        .memWdata    (memWdata),
        .memBe       (memBe),
        .storeDone   (storeDone),
        .misalignErr (misalignErr)
    );

    always #5 clk = ~clk;

    // Byte-by-byte model: each stored byte lands in the word holding its address.
    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] data, output bit rej, output int nbeats,
                             output logic [31:0] a0, output logic [31:0] a1,
                             output logic [31:0] d0, output logic [31:0] d1,
                             output logic [3:0] b0, output logic [3:0] b1);
        int sz;
        int lane;
        logic [31:0] ba;
        logic [31:0] off;
        sz = 1 << size;
        a0 = addr & ~32'(NB - 1);
        a1 = a0 + 32'(NB);
        d0 = '0; d1 = '0; b0 = '0; b1 = '0;
        rej = (size == 2'd3);
`ifndef MISALIGN_SPLIT_EN
        if ((addr % 32'(sz)) != 0) rej = 1'b1;
`endif
        for (int i = 0; i < sz && i < int'(NB); i++) begin
            ba   = addr + 32'(i);
            off  = ba - a0;
            lane = int'(ba % NB);
            if (off < NB) begin
                d0[8*lane +: 8] = data[8*i +: 8];
                b0[lane] = 1'b1;
            end else begin
                d1[8*lane +: 8] = data[8*i +: 8];
                b1[lane] = 1'b1;
            end
        end
        nbeats = (b1 != 0) ? 2 : 1;
    endtask

    task automatic do_store(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] data, input int stall);
        bit          rej;
        int          nb;
        int          w;
        logic [31:0] ea[2];
        logic [31:0] ed[2];
        logic [3:0]  eb[2];
        ref_store(size, addr, data, rej, nb, ea[0], ea[1], ed[0], ed[1], eb[0], eb[1]);
        w = 0;
        while (reqReady !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait: got %b want 1", reqReady);
            return;
        end
        reqValid  = 1'b1;
        storeSize = size;
        storeAddr = addr;
        storeData = data;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        if (rej) begin
            checks++;
            if ({misalignErr, memValid, storeDone, reqReady} !== 4'b1001) begin
                errors++;
                $display("FAIL reject_pulse size=%0d addr=%h: got err/valid/done/ready=%b want 1001",
                         size, addr, {misalignErr, memValid, storeDone, reqReady});
            end
            @(negedge clk);
            checks++;
            if ({misalignErr, memValid} !== 2'b00) begin
                errors++;
                $display("FAIL reject_clear: got err/valid=%b want 00", {misalignErr, memValid});
            end
        end else begin
            for (int b = 0; b < nb; b++) begin
                checks++;
                if ({memValid, storeDone, reqReady, memAddr, memWdata, memBe} !==
                    {1'b1, 1'b0, 1'b0, ea[b], ed[b], eb[b]}) begin
                    errors++;
                    $display("FAIL beat%0d size=%0d addr=%h: got v/d/r=%b a=%h d=%h be=%b want 100 a=%h d=%h be=%b",
                             b, size, addr, {memValid, storeDone, reqReady}, memAddr, memWdata,
                             memBe, ea[b], ed[b], eb[b]);
                end
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    checks++;
                    if ({memValid, storeDone, memAddr, memWdata, memBe} !==
                        {1'b1, 1'b0, ea[b], ed[b], eb[b]}) begin
                        errors++;
                        $display("FAIL stall_hold beat%0d cyc%0d: got v/d=%b a=%h d=%h be=%b want 10 a=%h d=%h be=%b",
                                 b, s, {memValid, storeDone}, memAddr, memWdata, memBe,
                                 ea[b], ed[b], eb[b]);
                    end
                end
                memReady = 1'b1;
                @(negedge clk);
                memReady = 1'b0;
            end
            checks++;
            if ({storeDone, memValid, reqReady, misalignErr} !== 4'b1010) begin
                errors++;
                $display("FAIL done_pulse addr=%h: got done/valid/ready/err=%b want 1010",
                         addr, {storeDone, memValid, reqReady, misalignErr});
            end
            @(negedge clk);
            checks++;
            if (storeDone !== 1'b0) begin
                errors++;
                $display("FAIL done_clear: got %b want 0", storeDone);
            end
        end
    endtask

    task automatic test_reset();
        resetN    = 1'b0;
        reqValid  = 1'b0;
        memReady  = 1'b0;
        storeSize = '0;
        storeAddr = '0;
        storeData = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({reqReady, memValid, storeDone, misalignErr, memAddr, memWdata, memBe} !== {4'b1000, 68'd0}) begin
            errors++;
            $display("FAIL reset_state: got r/v/d/e=%b a=%h d=%h be=%b want 1000 zeros",
                     {reqReady, memValid, storeDone, misalignErr}, memAddr, memWdata, memBe);
        end
        resetN = 1'b1;
        @(negedge clk);
        checks++;
        if ({reqReady, memValid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got ready/valid=%b want 10", {reqReady, memValid});
        end
    endtask

    task automatic test_directed();
        do_store(2'd0, 32'h0000_1003, 32'hAABB_CC5A, 0);
        do_store(2'd1, 32'h0000_2002, 32'h0000_BEEF, 1);
        do_store(2'd2, 32'h0000_3002, 32'h1122_3344, 2);
        do_store(2'd3, 32'h0000_0040, 32'h1234_5678, 0);
        do_store(2'd1, 32'h0000_1003, 32'h0000_A55A, 0);
        do_store(2'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0);
        do_store(2'd2, 32'h0000_0010, 32'h0102_0304, 0);
    endtask

    task automatic test_stall();
        do_store(2'd2, 32'h0000_5000, 32'hDEAD_BEEF, 5);
    endtask

    task automatic test_back_to_back();
        memReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (reqReady !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b want 1", i, reqReady);
            end
            reqValid  = 1'b1;
            storeSize = 2'd2;
            storeAddr = 32'h0000_0100 + 32'(4 * i);
            storeData = 32'hA000_0000 + 32'(i);
            @(posedge clk);
            @(negedge clk);
            reqValid = 1'b0;
            checks++;
            if ({memValid, reqReady, memAddr, memWdata, memBe} !==
                {2'b10, 32'h0000_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'b1111}) begin
                errors++;
                $display("FAIL b2b_beat%0d: got v/r=%b a=%h d=%h be=%b", i,
                         {memValid, reqReady}, memAddr, memWdata, memBe);
            end
            @(negedge clk);
            checks++;
            if ({storeDone, reqReady, memValid} !== 3'b110) begin
                errors++;
                $display("FAIL b2b_done%0d: got done/ready/valid=%b want 110", i,
                         {storeDone, reqReady, memValid});
            end
        end
        memReady = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            if ((i % 10) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            do_store(2'($urandom_range(0, 3)), a, $urandom, $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        reqValid  = 1'b1;
        storeSize = 2'd2;
`ifdef MISALIGN_SPLIT_EN
        storeAddr = 32'h0000_3002;
`else
        storeAddr = 32'h0000_3000;
`endif
        storeData = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        memReady = 1'b1;
        @(negedge clk);
        memReady = 1'b0;
        checks++;
        if ({memValid, memAddr, memWdata, memBe} !== {1'b1, 32'h0000_3004, 32'h0000_1122, 4'b0011}) begin
            errors++;
            $display("FAIL mid_beat1: got v=%b a=%h d=%h be=%b want 1 00003004 00001122 0011",
                     memValid, memAddr, memWdata, memBe);
        end
`endif
        #2 resetN = 1'b0;
        #1;
        checks++;
        if ({memValid, reqReady, storeDone, memAddr, memWdata, memBe} !== {3'b010, 68'd0}) begin
            errors++;
            $display("FAIL mid_reset: got v/r/d=%b a=%h d=%h be=%b want 010 zeros",
                     {memValid, reqReady, storeDone}, memAddr, memWdata, memBe);
        end
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        do_store(2'd2, 32'h0000_6000, 32'h5566_7788, 1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
